// File: rtl/m_trap_sequencer.sv
// m_trap_sequencer: sequences traps, returns, WFI sleep and SFENCE.VMA
// TLB-flush handshakes between decode and the CSR file / MMU.
module m_trap_sequencer #(
  parameter int N_SRC       = 4,
  parameter int EXC_W       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC-1:0]       exc_req_i,
  input  logic [N_SRC*EXC_W-1:0] exc_code_i,
  input  logic                   sys_valid_i,
  input  logic [2:0]             sys_ops_i,
  input  logic [1:0]             priv_mode_i,
  input  logic                   irq_pending_i,
  input  logic                   tlb_flush_ack_i,
  output logic                   stall_o,
  output logic                   flush_o,
  output logic                   trap_taken_o,
  output logic [EXC_W-1:0]       trap_code_o,
  output logic                   ret_taken_o,
  output logic                   ret_is_mret_o,
  output logic                   wfi_wake_o,
  output logic                   tlb_flush_req_o,
  output logic                   tlb_flush_timeout_o,
  output logic [CNT_W-1:0]       trap_count_o,
  output logic                   busy_o
);

  localparam logic [2:0] OP_SRET  = 3'd1;
  localparam logic [2:0] OP_WFI   = 3'd2;
  localparam logic [2:0] OP_MRET  = 3'd3;
  localparam logic [2:0] OP_SFVMA = 3'd4;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [EXC_W-1:0] CODE_ILLEGAL = EXC_W'(2);

  localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP,
    S_RET,
    S_WFI_WAIT,
    S_SF_REQ,
    S_SF_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [EXC_W-1:0] trap_code_q, trap_code_d;
  logic             ret_is_mret_q, ret_is_mret_d;
  logic             wfi_wake_q, wfi_wake_d;
  logic             timeout_q, timeout_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] trap_count_q, trap_count_d;
  logic             stall_q, stall_d;
  logic             flush_q, flush_d;
  logic             trap_taken_q, trap_taken_d;
  logic             ret_taken_q, ret_taken_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;

  logic [EXC_W-1:0] pick_code;
  logic             sys_illegal;

  // Fixed-priority pick: scanning downward lets the lowest set index win.
  always_comb begin
    pick_code = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (exc_req_i[i]) begin
        pick_code = exc_code_i[i*EXC_W +: EXC_W];
      end
    end
  end

  // Privilege check of the system op; reserved encodings are illegal too.
  always_comb begin
    sys_illegal = 1'b0;
    if (sys_ops_i == OP_SRET && priv_mode_i == PRIV_U) sys_illegal = 1'b1;
    if (sys_ops_i == OP_MRET && priv_mode_i != PRIV_M) sys_illegal = 1'b1;
    if (sys_ops_i == OP_WFI  && priv_mode_i == PRIV_U) sys_illegal = 1'b1;
    if (sys_ops_i > OP_SFVMA)                          sys_illegal = 1'b1;
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    trap_code_d   = trap_code_q;
    ret_is_mret_d = ret_is_mret_q;
    wfi_wake_d    = 1'b0;
    timeout_d     = timeout_q;
    to_cnt_d      = to_cnt_q;
    trap_count_d  = trap_count_q;

    case (state_q)
      S_IDLE: begin
        if (|exc_req_i) begin
          state_d     = S_TRAP;
          trap_code_d = pick_code;
        end else if (sys_valid_i) begin
          if (sys_illegal) begin
            state_d     = S_TRAP;
            trap_code_d = CODE_ILLEGAL;
          end else begin
            case (sys_ops_i)
              OP_SRET, OP_MRET: begin
                state_d       = S_RET;
                ret_is_mret_d = (sys_ops_i == OP_MRET);
              end
              OP_WFI: begin
                if (irq_pending_i) begin
                  wfi_wake_d = 1'b1;
                end else begin
                  state_d = S_WFI_WAIT;
                end
              end
              OP_SFVMA: begin
                state_d  = S_SF_REQ;
                to_cnt_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      S_TRAP:    state_d = S_IDLE;
      S_RET:     state_d = S_IDLE;
      S_WFI_WAIT: begin
        if (irq_pending_i) begin
          wfi_wake_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_SF_REQ: begin
        if (tlb_flush_ack_i) begin
          state_d = S_SF_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_SF_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_SF_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (state_d == S_TRAP && trap_count_q != '1) begin
      trap_count_d = trap_count_q + CNT_W'(1);
    end
  end

  // Output decode of the upcoming state.
  always_comb begin
    stall_d      = (state_d != S_IDLE);
    busy_d       = (state_d != S_IDLE);
    flush_d      = (state_d == S_TRAP) || (state_d == S_RET) || (state_d == S_SF_DONE);
    trap_taken_d = (state_d == S_TRAP);
    ret_taken_d  = (state_d == S_RET);
    req_d        = (state_d == S_SF_REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      trap_code_q   <= '0;
      ret_is_mret_q <= 1'b0;
      wfi_wake_q    <= 1'b0;
      timeout_q     <= 1'b0;
      to_cnt_q      <= '0;
      trap_count_q  <= '0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      trap_taken_q  <= 1'b0;
      ret_taken_q   <= 1'b0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      trap_code_q   <= trap_code_d;
      ret_is_mret_q <= ret_is_mret_d;
      wfi_wake_q    <= wfi_wake_d;
      timeout_q     <= timeout_d;
      to_cnt_q      <= to_cnt_d;
      trap_count_q  <= trap_count_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      trap_taken_q  <= trap_taken_d;
      ret_taken_q   <= ret_taken_d;
      req_q         <= req_d;
      busy_q        <= busy_d;
    end
  end

  assign stall_o             = stall_q;
  assign flush_o             = flush_q;
  assign trap_taken_o        = trap_taken_q;
  assign trap_code_o         = trap_code_q;
  assign ret_taken_o         = ret_taken_q;
  assign ret_is_mret_o       = ret_is_mret_q;
  assign wfi_wake_o          = wfi_wake_q;
  assign tlb_flush_req_o     = req_q;
  assign tlb_flush_timeout_o = timeout_q;
  assign trap_count_o        = trap_count_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_m_trap_sequencer.sv
// Directed testbench for m_trap_sequencer; a second instance with a 2-bit
// trap counter shares all inputs to observe saturation.
module tb_m_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  excReq;
  logic [15:0] excCode;
  logic        sysValid;
  logic [2:0]  sysOps;
  logic [1:0]  privMode;
  logic        irqPending;
  logic        tlbFlushAck;

  logic        stall, flush, trapTaken, retTaken, retIsMret, wfiWake;
  logic        tlbFlushReq, tlbFlushTimeout, busy;
  logic [3:0]  trapCode;
  logic [15:0] trapCount;

  logic        satStall, satFlush, satTrapTaken, satRetTaken, satRetIsMret, satWfiWake;
  logic        satReq, satTimeout, satBusy;
  logic [3:0]  satTrapCode;
  logic [1:0]  satTrapCount;

  int checks = 0;
  int failures = 0;

  m_trap_sequencer #(.N_SRC(4), .EXC_W(4), .ACK_TIMEOUT(16), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .exc_req_i(excReq), .exc_code_i(excCode),
    .sys_valid_i(sysValid), .sys_ops_i(sysOps), .priv_mode_i(privMode),
    .irq_pending_i(irqPending), .tlb_flush_ack_i(tlbFlushAck),
    .stall_o(stall), .flush_o(flush), .trap_taken_o(trapTaken),
    .trap_code_o(trapCode), .ret_taken_o(retTaken), .ret_is_mret_o(retIsMret),
    .wfi_wake_o(wfiWake), .tlb_flush_req_o(tlbFlushReq),
    .tlb_flush_timeout_o(tlbFlushTimeout), .trap_count_o(trapCount), .busy_o(busy)
  );

  m_trap_sequencer #(.N_SRC(4), .EXC_W(4), .ACK_TIMEOUT(16), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .exc_req_i(excReq), .exc_code_i(excCode),
    .sys_valid_i(sysValid), .sys_ops_i(sysOps), .priv_mode_i(privMode),
    .irq_pending_i(irqPending), .tlb_flush_ack_i(tlbFlushAck),
    .stall_o(satStall), .flush_o(satFlush), .trap_taken_o(satTrapTaken),
    .trap_code_o(satTrapCode), .ret_taken_o(satRetTaken), .ret_is_mret_o(satRetIsMret),
    .wfi_wake_o(satWfiWake), .tlb_flush_req_o(satReq),
    .tlb_flush_timeout_o(satTimeout), .trap_count_o(satTrapCount), .busy_o(satBusy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] req, input logic [15:0] code,
                               input logic sv, input logic [2:0] op,
                               input logic [1:0] priv, input logic irq,
                               input logic ack);
    excReq      = req;
    excCode     = code;
    sysValid    = sv;
    sysOps      = op;
    privMode    = priv;
    irqPending  = irq;
    tlbFlushAck = ack;
  endtask

  task automatic applyIdle();
    applyStimulus(4'b0000, 16'h0000, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyIdle();
    tick();
    tick();
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(trapCount), 32'd0);
    checkOutput("rst_code", 32'(trapCode), 32'd0);
    checkOutput("rst_req", 32'(tlbFlushReq), 32'd0);
    rst = 1'b0;
    tick();

    // Exception beats a simultaneous MRET; src1 wins over src3.
    applyStimulus(4'b1010, 16'h7050, 1'b1, 3'd3, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("prio_trap", 32'(trapTaken), 32'd1);
    checkOutput("prio_code", 32'(trapCode), 32'd5);
    checkOutput("prio_flush", 32'(flush), 32'd1);
    checkOutput("prio_stall", 32'(stall), 32'd1);
    checkOutput("prio_noret", 32'(retTaken), 32'd0);
    checkOutput("prio_count", 32'(trapCount), 32'd1);
    tick();
    checkOutput("prio_pulse_end", 32'(trapTaken), 32'd0);
    checkOutput("prio_idle", 32'(busy), 32'd0);
    checkOutput("prio_code_held", 32'(trapCode), 32'd5);

    // MRET from S-mode is illegal.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd3, 2'd1, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("mret_s_trap", 32'(trapTaken), 32'd1);
    checkOutput("mret_s_code", 32'(trapCode), 32'd2);
    checkOutput("mret_s_count", 32'(trapCount), 32'd2);
    tick();

    // SRET from S-mode returns.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd1, 2'd1, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("sret_ret", 32'(retTaken), 32'd1);
    checkOutput("sret_mret", 32'(retIsMret), 32'd0);
    checkOutput("sret_flush", 32'(flush), 32'd1);
    checkOutput("sret_notrap", 32'(trapTaken), 32'd0);
    tick();
    checkOutput("sret_pulse_end", 32'(retTaken), 32'd0);

    // MRET from M-mode returns with the MRET qualifier.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd3, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("mret_ret", 32'(retTaken), 32'd1);
    checkOutput("mret_mret", 32'(retIsMret), 32'd1);
    tick();

    // Reserved op traps as illegal.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd6, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("rsvd_trap", 32'(trapTaken), 32'd1);
    checkOutput("rsvd_code", 32'(trapCode), 32'd2);
    tick();

    // WFI from U-mode is illegal.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd2, 2'd0, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("wfi_u_trap", 32'(trapTaken), 32'd1);
    checkOutput("wfi_u_count", 32'(trapCount), 32'd4);
    tick();

    // Valid NONE op is a no-op.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd0, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("none_busy", 32'(busy), 32'd0);
    checkOutput("none_flush", 32'(flush), 32'd0);

    // WFI sleeps for 10 cycles, an exception is held while asleep.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd2, 2'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0100, 16'h0900, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0);
    checkOutput("wfi_stall_0", 32'(stall), 32'd1);
    checkOutput("wfi_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 10; i++) begin
      tick();
      checkOutput($sformatf("wfi_stall_%0d", i), 32'(stall), 32'd1);
    end
    checkOutput("wfi_nowake", 32'(wfiWake), 32'd0);
    irqPending = 1'b1;
    tick();
    irqPending = 1'b0;
    checkOutput("wfi_wake", 32'(wfiWake), 32'd1);
    checkOutput("wfi_wake_stall", 32'(stall), 32'd0);
    checkOutput("wfi_wake_noflush", 32'(flush), 32'd0);
    tick();
    applyIdle();
    checkOutput("held_exc_trap", 32'(trapTaken), 32'd1);
    checkOutput("held_exc_code", 32'(trapCode), 32'd9);
    checkOutput("held_exc_count", 32'(trapCount), 32'd5);
    checkOutput("sat_count", 32'(satTrapCount), 32'd3);
    tick();
    checkOutput("wake_pulse_end", 32'(wfiWake), 32'd0);

    // WFI with an interrupt already pending wakes immediately.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd2, 2'd3, 1'b1, 1'b0);
    tick();
    applyIdle();
    checkOutput("wfi_imm_wake", 32'(wfiWake), 32'd1);
    checkOutput("wfi_imm_stall", 32'(stall), 32'd0);
    checkOutput("wfi_imm_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("wfi_imm_end", 32'(wfiWake), 32'd0);

    // Stray ack in IDLE is ignored.
    tlbFlushAck = 1'b1;
    tick();
    tlbFlushAck = 1'b0;
    checkOutput("stray_ack_busy", 32'(busy), 32'd0);
    checkOutput("stray_ack_req", 32'(tlbFlushReq), 32'd0);

    // SFENCE.VMA acknowledged on the third cycle.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd4, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("sf_req_0", 32'(tlbFlushReq), 32'd1);
    checkOutput("sf_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("sf_req_1", 32'(tlbFlushReq), 32'd1);
    tick();
    checkOutput("sf_req_2", 32'(tlbFlushReq), 32'd1);
    tlbFlushAck = 1'b1;
    tick();
    tlbFlushAck = 1'b0;
    checkOutput("sf_req_drop", 32'(tlbFlushReq), 32'd0);
    checkOutput("sf_done_flush", 32'(flush), 32'd1);
    checkOutput("sf_done_stall", 32'(stall), 32'd1);
    checkOutput("sf_no_timeout", 32'(tlbFlushTimeout), 32'd0);
    tick();
    checkOutput("sf_idle", 32'(busy), 32'd0);
    checkOutput("sf_idle_flush", 32'(flush), 32'd0);

    // SFENCE.VMA never acknowledged times out after 16 cycles.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd4, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("to_req_0", 32'(tlbFlushReq), 32'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      checkOutput($sformatf("to_req_%0d", i), 32'(tlbFlushReq), 32'd1);
    end
    checkOutput("to_not_yet", 32'(tlbFlushTimeout), 32'd0);
    tick();
    checkOutput("to_req_drop", 32'(tlbFlushReq), 32'd0);
    checkOutput("to_flag", 32'(tlbFlushTimeout), 32'd1);
    checkOutput("to_done_flush", 32'(flush), 32'd1);
    tick();
    tick();
    checkOutput("to_sticky", 32'(tlbFlushTimeout), 32'd1);
    checkOutput("to_idle", 32'(busy), 32'd0);

    // Held exception: traps in back-to-back pairs, two cycles apart.
    applyStimulus(4'b0001, 16'h0003, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_trap_a", 32'(trapTaken), 32'd1);
    checkOutput("b2b_code", 32'(trapCode), 32'd3);
    tick();
    checkOutput("b2b_gap", 32'(trapTaken), 32'd0);
    tick();
    applyIdle();
    checkOutput("b2b_trap_b", 32'(trapTaken), 32'd1);
    checkOutput("b2b_count", 32'(trapCount), 32'd7);
    tick();

    // Reset held for two cycles in the middle of SF_REQ.
    applyStimulus(4'b0000, 16'h0000, 1'b1, 3'd4, 2'd3, 1'b0, 1'b0);
    tick();
    applyIdle();
    checkOutput("rst_sf_req", 32'(tlbFlushReq), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_sf_drop", 32'(tlbFlushReq), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_req", 32'(tlbFlushReq), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_count", 32'(trapCount), 32'd0);
    checkOutput("post_rst_timeout", 32'(tlbFlushTimeout), 32'd0);
    checkOutput("post_rst_sat", 32'(satTrapCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_trap_sequencer.md
Name: m_trap_sequencer

Overview:
- Sequential successor to the combinational system/exception decode path. It takes decoded exception requests from N_SRC pipeline sources and the decoded system op (SRET/WFI/MRET/SFENCE.VMA).
- It arbitrates the exception requests by fixed priority and checks privilege for the system op.
- It then runs a multi-cycle sequence: trap flush, return, WFI sleep, or SFENCE.VMA TLB-flush handshake with timeout. While a sequence runs it drives pipeline stall/flush.
- It sits between decode and the CSR file/MMU.

Parameters:
- N_SRC, 4, number of exception request sources; index 0 has the highest priority.
- EXC_W, 4, width of each exception code.
- ACK_TIMEOUT, 16, maximum cycles to wait for tlb_flush_ack before forcing completion; must be >= 2.
- CNT_W, 16, width of the saturating trap counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- exc_req  in  N_SRC  per-source exception request, level, sampled in IDLE only.
- exc_code  in  N_SRC*EXC_W  per-source code; source i occupies bits [i*EXC_W +: EXC_W].
- sys_valid  in  1  the sys_ops value is a valid instruction this cycle.
- sys_ops  in  3  0=NONE, 1=SRET, 2=WFI, 3=MRET, 4=SFENCE_VMA; 5-7 are reserved.
- priv_mode  in  2  current privilege: 3=M, 1=S, 0=U.
- irq_pending  in  1  any enabled interrupt pending.
- tlb_flush_ack  in  1  MMU acknowledges the flush.
- stall  out  1  freeze the upstream pipeline.
- flush  out  1  one-cycle pipeline flush pulse.
- trap_taken  out  1  one-cycle pulse: CSR file enters the trap.
- trap_code  out  EXC_W  cause, valid while trap_taken=1; held otherwise.
- ret_taken  out  1  one-cycle pulse: return executed.
- ret_is_mret  out  1  qualifies ret_taken: 1=MRET, 0=SRET.
- wfi_wake  out  1  one-cycle pulse when WFI exits.
- tlb_flush_req  out  1  level; held until ack or timeout.
- tlb_flush_timeout  out  1  sticky error flag; cleared only by rst.
- trap_count  out  CNT_W  number of traps taken; saturates at all-ones.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. All outputs 0, trap_code=0, trap_count=0, timeout counter=0. Reset mid-sequence aborts it immediately; tlb_flush_req drops the next cycle, with no ack wait.
- States: IDLE, TRAP, RET, WFI_WAIT, SF_REQ, SF_DONE. All outputs are registered.
- IDLE decision, in priority order, each sampled at the clk edge:
  - 1) Any exc_req bit set: pick the lowest set index i; latch trap_code=exc_code[i]; go to TRAP. sys_valid is ignored that cycle.
  - 2) sys_valid with SRET and priv_mode=U, or MRET and priv_mode!=M, or WFI and priv_mode=U, or sys_ops 5-7: latch trap_code=2 (illegal instruction); go to TRAP.
  - 3) sys_valid with SRET/MRET: latch ret_is_mret=(MRET); go to RET.
  - 4) sys_valid with WFI: if irq_pending=1 that same cycle, go to RET-less wake (wfi_wake pulse, stay IDLE). Otherwise go to WFI_WAIT.
  - 5) sys_valid with SFENCE_VMA: go to SF_REQ; tlb_flush_req=1; timeout counter=0.
  - 6) Otherwise stay in IDLE.
  - sys_ops=NONE with sys_valid=1 is a no-op.
- TRAP, 1 cycle: trap_taken=1, flush=1, stall=1. trap_count increments unless all-ones. Next state is IDLE.
- RET, 1 cycle: ret_taken=1, flush=1, stall=1. Next state is IDLE.
- WFI_WAIT: stall=1. Leaves when irq_pending=1: wfi_wake=1 for 1 cycle, then IDLE. No flush on wake. There is no time limit.
- SF_REQ: stall=1, tlb_flush_req=1, counter increments each cycle.
  - On ack=1: drop the req next cycle and go to SF_DONE.
  - On counter=ACK_TIMEOUT-1 without ack: set tlb_flush_timeout=1, drop req, go to SF_DONE.
  - Ack and timeout in the same cycle: the ack wins and no timeout flag is set.
- SF_DONE, 1 cycle: flush=1, stall=1. Next state is IDLE.
- stall is 0 in IDLE. Requests are not queued: upstream must hold an instruction while stall=1, and the FSM samples only in IDLE.
- Exceptions arriving while busy are ignored until IDLE. The source is required to hold them.
- Back-to-back: a new request in the cycle following the return to IDLE is accepted. Minimum spacing is therefore 2 cycles per trap.
- tlb_flush_ack while not in SF_REQ is ignored.

Test Plan:
- rst high for 2 cycles mid-SF_REQ -> tlb_flush_req=0, busy=0, trap_count=0 the cycle after rst deasserts.
- exc_req=4'b1010, codes src1=5, src3=7, with sys_valid=1 MRET in M-mode -> one cycle later trap_taken=1, trap_code=5, flush=1; no ret_taken; trap_count=1.
- sys_valid MRET with priv_mode=S -> trap_taken, trap_code=2. SRET with priv_mode=S -> ret_taken=1, ret_is_mret=0, flush=1.
- WFI in M-mode with irq_pending=0, then irq_pending=1 after 10 cycles -> stall=1 for those 10 cycles, wfi_wake pulse, then IDLE. WFI with irq_pending=1 already set -> immediate wfi_wake and stall stays 0.
- SFENCE_VMA with ack after 3 cycles -> req high 3-4 cycles, SF_DONE flush, no timeout. SFENCE_VMA with no ack and ACK_TIMEOUT=16 -> req drops after 16 cycles, tlb_flush_timeout=1 sticky.
- CNT_W=2 with 5 traps -> trap_count=3 (saturated). Exceptions held during WFI_WAIT are taken right after wake.
